// File: rtl/nibble_serial_add_ctrl_if.sv
// Bus bundle for the nibble-serial adder sequencer: requester handshake,
// operands/results, and the link to the external 4-bit adder slice.
interface nibble_serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // requester side
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  // adder slice side
  logic         add_c0;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic [3:0]   add_s;

  // controller view
  modport slave (
    input  start, a, b, cin, add_s,
    output busy, done, sum, cout, ovf, add_c0, add_a, add_b
  );

  // requester + slice view
  modport master (
    output start, a, b, cin, add_s,
    input  busy, done, sum, cout, ovf, add_c0, add_a, add_b
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial W-bit adder sequencer. Time-shares one external 4-bit slice
// (no carry-out pin), one nibble per cycle, LSB first. The slice carry-out is
// rebuilt from its MSB inputs and MSB sum output.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;      // operand A, shifted right one nibble per step
  logic [W-1:0]    b_q, b_d;      // operand B, shifted right one nibble per step
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [3:0]      add_a_c, add_b_c;
  logic            add_c0_c;
  logic            carry_k;       // recovered carry-out of the slice
  logic [NIBBLES-1:0] nib_sel;    // one-hot: nibble being written this cycle

  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_sel
      assign nib_sel[gi] = (idx_q == IDXW'(gi));
    end
  endgenerate

  // Next-state, datapath updates and slice drive
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    add_a_c  = 4'h0;
    add_b_c  = 4'h0;
    add_c0_c = 1'b0;
    carry_k  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        add_a_c  = a_q[3:0];
        add_b_c  = b_q[3:0];
        add_c0_c = carry_q;
        // generate, or propagate when the MSB sum bit shows a carry-in was absorbed
        carry_k  = (add_a_c[3] & add_b_c[3]) |
                   ((add_a_c[3] ^ add_b_c[3]) & ~bus.add_s[3]);
        carry_d  = carry_k;
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        for (int n = 0; n < NIBBLES; n++) begin
          if (nib_sel[n]) sum_d[4*n +: 4] = bus.add_s;
        end
        if (idx_q == IDXW'(NIBBLES - 1)) begin
          cout_d  = carry_k;
          // carry into the sign bit differs from carry out of it
          ovf_d   = (add_a_c[3] ^ add_b_c[3] ^ bus.add_s[3]) ^ carry_k;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.sum    = sum_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.add_a  = add_a_c;
  assign bus.add_b  = add_b_c;
  assign bus.add_c0 = add_c0_c;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (16-bit configuration).
// A transaction-level arithmetic model predicts busy/done/results and the
// nibble/carry presented to the slice each cycle; literal cases pin the model.
module tb_nibble_serial_add_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // behavioural 4-bit slice: sum only, carry-out discarded
  logic [4:0] slice_full;
  assign slice_full = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_c0};
  assign bus.add_s  = slice_full[3:0];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // {ovf, cout, sum} of a W-bit two's-complement add
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    logic [W:0] full;
    logic       ov;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    ov   = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {ov, full};
  endfunction

  // carry into bit 4*j of x+y+c
  function automatic logic carry_into(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic c, input int j);
    logic [W:0] mask;
    logic [W:0] t;
    mask = ({{W{1'b0}}, 1'b1} << (4 * j)) - 1'b1;
    t    = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {{W{1'b0}}, c};
    return t[4*j];
  endfunction

  // transaction model: cnt = cycles left until idle (1 = done cycle)
  int           cnt    = 0;
  logic [W-1:0] opa    = '0;
  logic [W-1:0] opb    = '0;
  logic         opc    = 1'b0;
  logic [W-1:0] exp_s  = '0;
  logic         exp_co = 1'b0;
  logic         exp_ov = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 0;
      opa    <= '0;
      opb    <= '0;
      opc    <= 1'b0;
      exp_s  <= '0;
      exp_co <= 1'b0;
      exp_ov <= 1'b0;
    end else if (cnt == 0) begin
      if (bus.start) begin
        opa <= bus.a;
        opb <= bus.b;
        opc <= bus.cin;
        cnt <= NIBBLES + 1;
      end
    end else begin
      if (cnt == 2) {exp_ov, exp_co, exp_s} <= ref_add(opa, opb, opc);
      cnt <= cnt - 1;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    int           j;
    logic [W-1:0] sha, shb;
    if (rst_n) begin
      chk("busy", bus.busy, cnt > 0);
      chk("done", bus.done, cnt == 1);
      if (cnt >= 2) begin
        j   = NIBBLES + 1 - cnt;
        sha = opa >> (4 * j);
        shb = opb >> (4 * j);
        chk("add_a", bus.add_a, sha[3:0]);
        chk("add_b", bus.add_b, shb[3:0]);
        chk("add_c0", bus.add_c0, carry_into(opa, opb, opc, j));
      end else begin
        chk("add_a_idle", bus.add_a, 4'h0);
        chk("add_b_idle", bus.add_b, 4'h0);
        chk("add_c0_idle", bus.add_c0, 1'b0);
        chk("sum", bus.sum, exp_s);
        chk("cout", bus.cout, exp_co);
        chk("ovf", bus.ovf, exp_ov);
      end
      if (cnt == 1)
        $display("[TB] op a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d",
                 opa, opb, opc, bus.sum, bus.cout, bus.ovf);
    end
  end

  // one operation from an idle DUT; optionally pulse start mid-run
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input bit inject, output logic [W-1:0] s, output logic co,
                       output logic ov, output int lat, output logic [NIBBLES-1:0] c0s);
    c0s = '0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = ia; bus.b = ib; bus.cin = ic;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 50) begin
      if (lat < NIBBLES) c0s[lat] = bus.add_c0;
      if (inject && lat == 1) begin
        bus.start = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    s  = bus.sum;
    co = bus.cout;
    ov = bus.ovf;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]       s;
    logic               co, ov;
    int                 lat;
    logic [NIBBLES-1:0] c0s;
    int                 k, dones, t_prev;

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_sum", bus.sum, 16'h0000);
    chk("rst_add_a", bus.add_a, 4'h0);

    do_op(16'h0000, 16'h0000, 1'b0, 1'b0, s, co, ov, lat, c0s);
    chk("lat_zero", lat, 4);
    chk("zero_sum", s, 16'h0000);
    chk("zero_cout", co, 1'b0);

    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, s, co, ov, lat, c0s);
    chk("ffff_sum", s, 16'hFFFF);
    chk("ffff_cout", co, 1'b1);
    chk("ffff_ovf", ov, 1'b0);
    chk("ffff_c0_chain", c0s, 4'hF);

    do_op(16'h1234, 16'hABCD, 1'b1, 1'b0, s, co, ov, lat, c0s);
    chk("mix_sum", s, 16'hBE02);
    chk("mix_cout", co, 1'b0);
    chk("mix_ovf", ov, 1'b0);

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat, c0s);
    chk("prop_sum", s, 16'h0000);
    chk("prop_cout", co, 1'b1);
    chk("prop_ovf", ov, 1'b0);

    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat, c0s);
    chk("posovf_sum", s, 16'h8000);
    chk("posovf_cout", co, 1'b0);
    chk("posovf_ovf", ov, 1'b1);

    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, s, co, ov, lat, c0s);
    chk("negovf_sum", s, 16'h0000);
    chk("negovf_cout", co, 1'b1);
    chk("negovf_ovf", ov, 1'b1);

    // start pulsed during RUN must be ignored
    do_op(16'h1111, 16'h2222, 1'b0, 1'b1, s, co, ov, lat, c0s);
    chk("inject_sum", s, 16'h3333);
    chk("inject_lat", lat, 4);

    // start held high: back-to-back ops every NIBBLES+2 cycles
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
    k = 0; dones = 0; t_prev = 0;
    while (dones < 3 && k < 100) begin
      @(posedge clk); #1;
      k++;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      if (bus.done) begin
        if (dones > 0) chk("b2b_spacing", k - t_prev, NIBBLES + 2);
        t_prev = k;
        dones++;
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", dones, 3);

    // reset after two nibbles have been processed
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 16'h5555; bus.b = 16'h6666; bus.cin = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_sum", bus.sum, 16'h0000);
    chk("midrst_done", bus.done, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_no_done", bus.done, 1'b0);
    end
    rst_n = 1'b1;
    do_op(16'h00F0, 16'h0010, 1'b0, 1'b0, s, co, ov, lat, c0s);
    chk("postrst_sum", s, 16'h0100);
    chk("postrst_cout", co, 1'b0);

    // randomized operations with random idle gaps and mid-run start pulses
    repeat (30) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            s, co, ov, lat, c0s);
      chk("rand_lat", lat, NIBBLES);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
